// File: rtl/permutation_sequencer.sv
// Round-iteration controller and 320-bit state register that closes the ASCON permutation loop.
// Optional abort support is compiled in when PERM_ABORT_EN is defined.
module permutation_sequencer #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [4:0][63:0]  load_state_i,
  input  logic [4:0][63:0]  diff_state_i,
`ifdef PERM_ABORT_EN
  input  logic              abort_i,
  output logic              aborted_o,
`endif
  output logic [4:0][63:0]  state_o,
  output logic [3:0]        round_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned LAST_ROUND = 11;

  if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_rounds_a
    $error("permutation_sequencer: ROUNDS_A must be in 1..12");
  end
  if (ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_rounds_b
    $error("permutation_sequencer: ROUNDS_B must be in 1..12");
  end

  localparam logic [ROUND_W-1:0] FIRST_A = ROUND_W'(12 - ROUNDS_A);
  localparam logic [ROUND_W-1:0] FIRST_B = ROUND_W'(12 - ROUNDS_B);
  localparam logic [ROUND_W-1:0] LAST_R  = ROUND_W'(LAST_ROUND);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [4:0][63:0]   state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  // Next-state, datapath load/capture and registered-output decode
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    round_d   = round_q;
    aborted_d = 1'b0;
    case (fsm_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = load_state_i;
          round_d = mode_i ? FIRST_B : FIRST_A;
          fsm_d   = RUN;
        end else begin
          fsm_d = IDLE;
        end
      end
      RUN: begin
        state_d = diff_state_i;
`ifdef PERM_ABORT_EN
        // Abort wins over the final-round transition and discards this round's result
        if (abort_i) begin
          state_d   = state_q;
          fsm_d     = IDLE;
          aborted_d = 1'b1;
        end else
`endif
        if (round_q == LAST_R) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + ROUND_W'(1);
        end
      end
      default: fsm_d = IDLE;
    endcase
    busy_d = (fsm_d == RUN);
    done_d = (fsm_d == DONE);
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      round_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      round_q   <= round_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign state_o = state_q;
  assign round_o = round_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
`ifdef PERM_ABORT_EN
  assign aborted_o = aborted_q;
`else
  logic unused_aborted;
  assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_permutation_sequencer.sv
// Self-checking bench for permutation_sequencer: table-driven permutation jobs with a result
// scoreboard, plus hand-written back-to-back, ignored-start, mid-run reset and abort sequences.
module tb_permutation_sequencer;

  logic             clk = 1'b0;
  logic             resetb;
  logic             start;
  logic             mode;
  logic [4:0][63:0] load_state;
  logic [4:0][63:0] diff_state;
  logic [4:0][63:0] state;
  logic [3:0]       round;
  logic             busy;
  logic             done;
`ifdef PERM_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  int checks = 0;
  int errors = 0;

  permutation_sequencer #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
    .clock_i      (clk),
    .resetb_i     (resetb),
    .start_i      (start),
    .mode_i       (mode),
    .load_state_i (load_state),
    .diff_state_i (diff_state),
`ifdef PERM_ABORT_EN
    .abort_i      (abort),
    .aborted_o    (aborted),
`endif
    .state_o      (state),
    .round_o      (round),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  // Diffusion stub: word0 incremented once per round, other words pass through
  always_comb begin
    diff_state    = state;
    diff_state[0] = state[0] + 64'd1;
  end

  typedef struct {
    logic        mode;
    logic [63:0] w0;
    logic [63:0] w1;
    int          rounds;
    logic [63:0] exp_w0;
  } vec_t;

  typedef struct {
    logic [63:0] w0;
    logic [63:0] w1;
  } result_t;

  result_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic m, input logic [63:0] w0, input logic [63:0] w1);
    start         = 1'b1;
    mode          = m;
    load_state    = '0;
    load_state[0] = w0;
    load_state[1] = w1;
  endtask

  // Step through R rounds checking round/busy each cycle; ends in the DONE cycle
  task automatic run_rounds(input int r, input string tag);
    for (int k = 0; k < r; k++) begin
      check({tag, " round_o"}, 64'(round), 64'(12 - r + k));
      check({tag, " busy_o"}, 64'(busy), 64'd1);
      check({tag, " done_o low"}, 64'(done), 64'd0);
      tick();
    end
  endtask

  task automatic check_done(input string tag);
    result_t exp;
    check({tag, " done_o"}, 64'(done), 64'd1);
    check({tag, " busy_o low"}, 64'(busy), 64'd0);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue, expected a pending result", tag);
    end else begin
      exp = sb_q.pop_front();
      check({tag, " word0"}, state[0], exp.w0);
      check({tag, " word1"}, state[1], exp.w1);
    end
  endtask

  initial begin
    vec_t vecs[4];
    result_t r;
    logic [63:0] l0;

    vecs[0] = '{1'b0, 64'h80400c0600000000, 64'h0, 12, 64'h80400c060000000c};
    vecs[1] = '{1'b1, 64'h0, 64'h0, 6, 64'h6};
    vecs[2] = '{1'b0, 64'h0123456789abcdef, 64'hdeadbeefcafef00d, 12, 64'h0123456789abcdfb};
    vecs[3] = '{1'b1, 64'hfffffffffffffffc, 64'ha5a5a5a5a5a5a5a5, 6, 64'h0000000000000002};

    resetb     = 1'b0;
    start      = 1'b0;
    mode       = 1'b0;
    load_state = '0;
`ifdef PERM_ABORT_EN
    abort      = 1'b0;
`endif

    // Reset and idle
    repeat (3) tick();
    resetb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("idle state_o", 64'(state != '0), 64'd0);
      check("idle round_o", 64'(round), 64'd0);
      check("idle busy_o", 64'(busy), 64'd0);
      check("idle done_o", 64'(done), 64'd0);
      tick();
    end

    // Table-driven permutation jobs
    foreach (vecs[i]) begin
      drive_start(vecs[i].mode, vecs[i].w0, vecs[i].w1);
      r.w0 = vecs[i].exp_w0;
      r.w1 = vecs[i].w1;
      sb_q.push_back(r);
      tick();
      start = 1'b0;
      run_rounds(vecs[i].rounds, $sformatf("vec%0d", i));
      check_done($sformatf("vec%0d", i));
      tick();
      check($sformatf("vec%0d done single pulse", i), 64'(done), 64'd0);
      check($sformatf("vec%0d back to idle", i), 64'(busy), 64'd0);
      check($sformatf("vec%0d state holds", i), state[0], vecs[i].exp_w0);
      tick();
    end

    // Back-to-back: p^a then p^b started in the DONE cycle
    drive_start(1'b0, 64'h10, 64'h0);
    sb_q.push_back('{64'h1c, 64'h0});
    tick();
    start = 1'b0;
    run_rounds(12, "b2b first");
    check_done("b2b first");
    drive_start(1'b1, 64'h100, 64'h7);
    sb_q.push_back('{64'h106, 64'h7});
    tick();
    start = 1'b0;
    check("b2b rerun busy_o", 64'(busy), 64'd1);
    check("b2b rerun round_o", 64'(round), 64'd6);
    check("b2b rerun reload", state[0], 64'h100);
    run_rounds(6, "b2b second");
    check_done("b2b second");
    tick();

    // Start ignored mid-run, then synchronous reset aborts without a done pulse
    l0 = 64'h5000;
    drive_start(1'b0, l0, 64'h0);
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("midrun round 4", 64'(round), 64'd4);
    drive_start(1'b1, 64'hdead, 64'hbeef);
    tick();
    start = 1'b0;
    check("ignored start round_o", 64'(round), 64'd5);
    check("ignored start word0", state[0], l0 + 64'd5);
    check("ignored start word1", state[1], 64'h0);
    tick();
    tick();
    check("midrun round 7", 64'(round), 64'd7);
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("reset midrun busy_o", 64'(busy), 64'd0);
      check("reset midrun done_o", 64'(done), 64'd0);
      check("reset midrun state_o", 64'(state != '0), 64'd0);
      check("reset midrun round_o", 64'(round), 64'd0);
      tick();
    end

`ifdef PERM_ABORT_EN
    // Abort at the final round beats the DONE transition
    l0 = 64'h7700;
    drive_start(1'b0, l0, 64'h0);
    tick();
    start = 1'b0;
    repeat (11) tick();
    check("abort at round 11", 64'(round), 64'd11);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort aborted_o", 64'(aborted), 64'd1);
    check("abort done_o", 64'(done), 64'd0);
    check("abort busy_o", 64'(busy), 64'd0);
    check("abort state kept", state[0], l0 + 64'd11);
    tick();
    check("abort pulse single", 64'(aborted), 64'd0);
    check("abort no late done", 64'(done), 64'd0);
    check("abort state held", state[0], l0 + 64'd11);
`endif

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
